// File: rtl/demux_1t8_stream_pkg.sv
// Shared constants for the 1-to-8 stream demultiplexer.
//   DEMUX_CH    : number of output channels
//   DEMUX_SEL_W : width of the channel select
//   DEMUX_CNT_W : width of the full-slot counter (holds 0..DEMUX_CH)
package demux_1t8_stream_pkg;

    localparam int unsigned DEMUX_CH    = 8;
    localparam int unsigned DEMUX_SEL_W = 3;
    localparam int unsigned DEMUX_CNT_W = 4;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   fill        : load fill_data this cycle (only raised when can_accept=1)
//   fill_data   : payload to load
//   out_ready   : consumer takes the slot this cycle
//   full        : slot holds a beat (registered)
//   data        : slot payload (registered)
//   can_accept  : slot empty or being drained this cycle (combinational)
module demux_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             out_ready,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    // A drain and refill in the same cycle keeps the slot full with no bubble.
    assign can_accept = ~full | out_ready;

    // Slot state: fill wins over drain; data only changes on fill so it is
    // stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (fill) begin
            full <= 1'b1;
            data <= fill_data;
        end else if (full && out_ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1t8_stream.sv
// Registered 1-to-8 stream demultiplexer: routes each input beat to the
// one-entry output slot selected by in_sel.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in_sel     : destination channel of the input beat
//   in_data    : input payload
//   in_valid   : input beat present
//   in_ready   : selected slot can accept this cycle (combinational)
//   out_data   : channel k payload at [k*WIDTH +: WIDTH]
//   out_valid  : channel k slot full
//   out_ready  : consumer k takes its slot this cycle
//   pending    : number of full slots (registered)
module demux_1t8_stream
    import demux_1t8_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DEMUX_SEL_W-1:0]    in_sel,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DEMUX_CH*WIDTH-1:0] out_data,
    output logic [DEMUX_CH-1:0]       out_valid,
    input  logic [DEMUX_CH-1:0]       out_ready,
    output logic [DEMUX_CNT_W-1:0]    pending
);

    logic [DEMUX_CH-1:0]    can_accept;
    logic [DEMUX_CH-1:0]    fill;
    logic                   accept;
    logic [DEMUX_CNT_W-1:0] pending_nxt;

    assign in_ready = can_accept[in_sel];
    assign accept   = in_valid & in_ready;

    // One-hot fill vector for the selected slot.
    assign fill = accept ? (DEMUX_CH'(1) << in_sel) : '0;

    for (genvar k = 0; k < DEMUX_CH; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .fill       (fill[k]),
            .fill_data  (in_data),
            .out_ready  (out_ready[k]),
            .full       (out_valid[k]),
            .data       (out_data[k*WIDTH +: WIDTH]),
            .can_accept (can_accept[k])
        );
    end

    // Count tracks the slot flags: +1 filling an empty slot, -1 per slot
    // drained without refill; drain-and-refill is neutral.
    always_comb begin
        pending_nxt = pending;
        for (int unsigned k = 0; k < DEMUX_CH; k++) begin
            if (fill[k] && !out_valid[k]) begin
                pending_nxt = pending_nxt + DEMUX_CNT_W'(1);
            end else if (out_valid[k] && out_ready[k] && !fill[k]) begin
                pending_nxt = pending_nxt - DEMUX_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_demux_1t8_stream.sv
// Self-checking bench for demux_1t8_stream: directed scenarios plus a random
// run against per-channel queue scoreboards.
module tb_demux_1t8_stream;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst_n;
    logic [2:0]     in_sel;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [3:0]     pending;

    int n_total;
    int n_bad;

    demux_1t8_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    function automatic logic [W-1:0] chan(input int k);
        return out_data[k*W +: W];
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 8'hFF;
        drive(1'b0, 3'd0, '0);
        tick(); tick();
        n_total++;
        if (out_valid !== 8'h00) begin n_bad++; $display("FAIL reset_valid: got %h exp 00", out_valid); end
        n_total++;
        if (pending !== 4'd0) begin n_bad++; $display("FAIL reset_pending: got %0d exp 0", pending); end
        n_total++;
        if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h exp 0", out_data); end
        rst_n = 1'b1;
        tick();
        drive(1'b1, 3'd5, 32'hA5A5_0005);
        #1;
        n_total++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL first_ready: got %b exp 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, '0);
        n_total++;
        if (out_valid !== 8'h20) begin n_bad++; $display("FAIL first_valid: got %h exp 20", out_valid); end
        n_total++;
        if (chan(5) !== 32'hA5A5_0005) begin n_bad++; $display("FAIL first_data: got %h exp a5a50005", chan(5)); end
        n_total++;
        if (pending !== 4'd1) begin n_bad++; $display("FAIL first_pending: got %0d exp 1", pending); end
        tick();
        n_total++;
        if (out_valid !== 8'h00 || pending !== 4'd0) begin
            n_bad++; $display("FAIL first_drain: valid %h pending %0d exp 00/0", out_valid, pending);
        end
    endtask

    task automatic test_stall();
        out_ready = 8'h00;
        drive(1'b1, 3'd2, 32'h11);
        #1;
        n_total++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready1: got %b exp 1", in_ready); end
        tick();
        drive(1'b1, 3'd2, 32'h22);
        #1;
        n_total++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready2: got %b exp 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (chan(2) !== 32'h11 || out_valid !== 8'h04) begin
                n_bad++; $display("FAIL stall_hold: data %h valid %h exp 11/04", chan(2), out_valid);
            end
        end
        out_ready = 8'h04;
        #1;
        n_total++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b exp 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, '0);
        n_total++;
        if (chan(2) !== 32'h22 || out_valid !== 8'h04 || pending !== 4'd1) begin
            n_bad++; $display("FAIL stall_replace: data %h valid %h pend %0d exp 22/04/1", chan(2), out_valid, pending);
        end
        tick();
        n_total++;
        if (out_valid !== 8'h00 || pending !== 4'd0) begin
            n_bad++; $display("FAIL stall_drain: valid %h pend %0d exp 00/0", out_valid, pending);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 8'h80;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'd7, W'(i));
            #1;
            n_total++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: beat %0d got %b exp 1", i, in_ready); end
            if (i > 0) begin
                n_total++;
                if (out_valid !== 8'h80 || chan(7) !== W'(i - 1) || pending !== 4'd1) begin
                    n_bad++;
                    $display("FAIL b2b_out: beat %0d valid %h data %h pend %0d exp 80/%h/1", i, out_valid, chan(7), pending, W'(i - 1));
                end
            end
            tick();
        end
        drive(1'b0, 3'd0, '0);
        n_total++;
        if (chan(7) !== 32'd15 || out_valid !== 8'h80) begin
            n_bad++; $display("FAIL b2b_last: data %h valid %h exp f/80", chan(7), out_valid);
        end
        tick();
        n_total++;
        if (out_valid !== 8'h00 || pending !== 4'd0) begin
            n_bad++; $display("FAIL b2b_empty: valid %h pend %0d exp 00/0", out_valid, pending);
        end
    endtask

    task automatic test_fanout();
        out_ready = 8'h00;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), W'(k));
            tick();
        end
        drive(1'b0, 3'd0, '0);
        n_total++;
        if (pending !== 4'd8 || out_valid !== 8'hFF) begin
            n_bad++; $display("FAIL fan_full: pend %0d valid %h exp 8/ff", pending, out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (chan(k) !== W'(k)) begin n_bad++; $display("FAIL fan_data: ch %0d got %h exp %h", k, chan(k), W'(k)); end
        end
        drive(1'b1, 3'd6, 32'hDEAD);
        #1;
        n_total++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fan_ready_full: got %b exp 0", in_ready); end
        drive(1'b0, 3'd0, '0);
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
        n_total++;
        if (pending !== 4'd0 || out_valid !== 8'h00) begin
            n_bad++; $display("FAIL fan_drain: pend %0d valid %h exp 0/00", pending, out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 8'h00;
        drive(1'b1, 3'd1, 32'h101);
        tick();
        drive(1'b1, 3'd3, 32'h303);
        tick();
        drive(1'b0, 3'd0, '0);
        n_total++;
        if (out_valid !== 8'h0A || pending !== 4'd2) begin
            n_bad++; $display("FAIL arst_pre: valid %h pend %0d exp 0a/2", out_valid, pending);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 8'h00 || pending !== 4'd0 || out_data !== '0) begin
            n_bad++; $display("FAIL arst_now: valid %h pend %0d exp 00/0", out_valid, pending);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (out_valid !== 8'h00 || pending !== 4'd0 || out_data !== '0) begin
                n_bad++; $display("FAIL arst_after: valid %h pend %0d data %h exp empty", out_valid, pending, out_data);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q [0:7][$];
        logic         v;
        logic [2:0]   s;
        logic [W-1:0] d;
        logic [7:0]   r;
        logic         exp_rdy;
        int           exp_cnt;
        for (int c = 0; c < 3000; c++) begin
            v = 1'($urandom_range(0, 3) != 0);
            s = 3'($urandom_range(0, 7));
            d = $urandom;
            r = 8'($urandom);
            drive(v, s, d);
            out_ready = r;
            #1;
            exp_rdy = (q[s].size() == 0) || r[s];
            n_total++;
            if (in_ready !== exp_rdy) begin
                n_bad++; $display("FAIL rnd_ready: cyc %0d ch %0d got %b exp %b", c, s, in_ready, exp_rdy);
            end
            exp_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                exp_cnt += q[k].size();
                n_total++;
                if (out_valid[k] !== (q[k].size() != 0)) begin
                    n_bad++; $display("FAIL rnd_valid: cyc %0d ch %0d got %b exp %b", c, k, out_valid[k], q[k].size() != 0);
                end else if (q[k].size() != 0) begin
                    n_total++;
                    if (chan(k) !== q[k][0]) begin
                        n_bad++; $display("FAIL rnd_data: cyc %0d ch %0d got %h exp %h", c, k, chan(k), q[k][0]);
                    end
                end
            end
            n_total++;
            if (pending !== 4'(exp_cnt) || pending !== 4'($countones(out_valid))) begin
                n_bad++; $display("FAIL rnd_pending: cyc %0d got %0d exp %0d", c, pending, exp_cnt);
            end
            for (int k = 0; k < 8; k++) begin
                if (r[k] && q[k].size() != 0) void'(q[k].pop_front());
            end
            if (v && exp_rdy) q[s].push_back(d);
            tick();
        end
        drive(1'b0, 3'd0, '0);
        out_ready = 8'hFF;
        tick();
        n_total++;
        if (out_valid !== 8'h00 || pending !== 4'd0) begin
            n_bad++; $display("FAIL rnd_final: valid %h pend %0d exp 00/0", out_valid, pending);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_stall();
        test_back_to_back();
        test_fanout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
